// File: rtl/instruction_fetch_register_if.sv
// Bus between memory/decoder and the instruction fetch register: beat handshake plus held-word outputs.
interface instruction_fetch_register_if #(
  parameter int BUS_W   = 8,
  parameter int INSTR_W = 16
) ();
  localparam int CNT_W = $clog2(INSTR_W / BUS_W + 1);

  logic [BUS_W-1:0]   I;
  logic               IValid;
  logic               IReady;
  logic               Flush;
  logic               Consume;
  logic [INSTR_W-1:0] IROut;
  logic               IRValid;
  logic [CNT_W-1:0]   ByteCount;

  modport master (
    output I, IValid, Flush, Consume,
    input  IReady, IROut, IRValid, ByteCount
  );

  modport slave (
    input  I, IValid, Flush, Consume,
    output IReady, IROut, IRValid, ByteCount
  );
endinterface

// File: rtl/instruction_fetch_register.sv
// Assembles INSTR_W-bit instructions from BUS_W-bit memory beats and holds them for the decoder.
// Define IFR_DOUBLE_BUFFER_EN to let the next instruction fill while the current one is still held.
module instruction_fetch_register #(
  parameter int BUS_W     = 8,
  parameter int INSTR_W   = 16,
  parameter bit BIG_FIRST = 1'b1
) (
  input logic Clock,
  input logic Reset,
  instruction_fetch_register_if.slave bus
);
  localparam int NBEATS = INSTR_W / BUS_W;
  localparam int CNT_W  = $clog2(NBEATS + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  if ((INSTR_W % BUS_W) != 0 || NBEATS < 2) begin : gBadRatio
    $error("instruction_fetch_register: INSTR_W must be a multiple of BUS_W with at least two beats");
  end

  logic [0:0]         state;
  logic [INSTR_W-1:0] asmBuf;
  logic [INSTR_W-1:0] irOut;
  logic [INSTR_W-1:0] assembled;
  logic [CNT_W-1:0]   byteCount;
  logic               lastBeat;
  logic               ready;
  logic               accept;

  function automatic int slotLsb(input int k);
    return BIG_FIRST ? (INSTR_W - BUS_W * (k + 1)) : (BUS_W * k);
  endfunction

  assign lastBeat = (byteCount == CNT_W'(NBEATS - 1));

`ifdef IFR_DOUBLE_BUFFER_EN
  // Partial beats always flow; only the completing beat must wait for the held word to retire.
  assign ready = !bus.Flush && (!lastBeat || state == FILL || bus.Consume);
`else
  assign ready = !bus.Flush && (state == FILL || bus.Consume);
`endif

  assign accept = bus.IValid && ready;

  always_comb begin
    assembled = asmBuf;
    for (int k = 0; k < NBEATS; k++) begin
      if (byteCount == CNT_W'(k)) begin
        assembled[slotLsb(k) +: BUS_W] = bus.I;
      end
    end
  end

  // A completing beat goes straight to IROut, so it overrides a same-cycle Consume and stays FULL.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= FILL;
      asmBuf    <= '0;
      irOut     <= '0;
      byteCount <= '0;
    end else if (bus.Flush) begin
      state     <= FILL;
      byteCount <= '0;
    end else begin
      if (state == FULL && bus.Consume) begin
        state <= FILL;
      end
      if (accept) begin
        if (lastBeat) begin
          irOut     <= assembled;
          byteCount <= '0;
          state     <= FULL;
        end else begin
          asmBuf    <= assembled;
          byteCount <= byteCount + CNT_W'(1);
        end
      end
    end
  end

  assign bus.IReady    = ready;
  assign bus.IROut     = irOut;
  assign bus.IRValid   = (state == FULL);
  assign bus.ByteCount = byteCount;
endmodule

// File: tb/tb_instruction_fetch_register.sv
// Directed bench: a vector table on a 16-bit big-first instance plus hand sequences on little-first and 32-bit instances.
module tb_instruction_fetch_register;
  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  instruction_fetch_register_if #(.BUS_W(8), .INSTR_W(16)) busA ();
  instruction_fetch_register_if #(.BUS_W(8), .INSTR_W(16)) busB ();
  instruction_fetch_register_if #(.BUS_W(8), .INSTR_W(32)) busC ();

  instruction_fetch_register #(.BUS_W(8), .INSTR_W(16), .BIG_FIRST(1'b1)) dutA (
    .Clock(Clock), .Reset(Reset), .bus(busA)
  );
  instruction_fetch_register #(.BUS_W(8), .INSTR_W(16), .BIG_FIRST(1'b0)) dutB (
    .Clock(Clock), .Reset(Reset), .bus(busB)
  );
  instruction_fetch_register #(.BUS_W(8), .INSTR_W(32), .BIG_FIRST(1'b1)) dutC (
    .Clock(Clock), .Reset(Reset), .bus(busC)
  );

`ifdef IFR_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        iv;
    logic [7:0]  i;
    logic        flush;
    logic        consume;
    logic        rdyS;
    logic        rdyD;
    logic        irv;
    logic [1:0]  bc;
    logic [15:0] ir;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] i, input logic flush, input logic consume);
    busA.IValid  = iv;
    busA.I       = i;
    busA.Flush   = flush;
    busA.Consume = consume;
  endtask

  task automatic idleAll();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    busB.IValid = 1'b0; busB.I = 8'h00; busB.Flush = 1'b0; busB.Consume = 1'b0;
    busC.IValid = 1'b0; busC.I = 8'h00; busC.Flush = 1'b0; busC.Consume = 1'b0;
  endtask

  task automatic stepEdge();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkA(input string tag, input logic irv, input logic [1:0] bc, input logic [15:0] ir);
    checkOutput({tag, " IRValid"}, 32'(busA.IRValid), 32'(irv));
    checkOutput({tag, " ByteCount"}, 32'(busA.ByteCount), 32'(bc));
    checkOutput({tag, " IROut"}, 32'(busA.IROut), 32'(ir));
  endtask

  task automatic beatC(input logic [7:0] b, input logic flush, input logic [1:0] bcExp, input logic irvExp);
    busC.IValid = 1'b1;
    busC.I      = b;
    busC.Flush  = flush;
    #1;
    checkOutput($sformatf("C beat %h IReady", b), 32'(busC.IReady), 32'(!flush));
    stepEdge();
    checkOutput($sformatf("C beat %h ByteCount", b), 32'(busC.ByteCount), 32'(bcExp));
    checkOutput($sformatf("C beat %h IRValid", b), 32'(busC.IRValid), 32'(irvExp));
  endtask

  initial begin
    Reset = 1'b1;
    idleAll();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    checkA("reset", 1'b0, 2'd0, 16'h0000);

    //          iv    i      flush consume rdyS  rdyD  irv   bc    ir
    vecs[0]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0000};
    vecs[1]  = '{1'b1, 8'hCD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'hABCD};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'hABCD};
    vecs[3]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 16'hABCD};
    vecs[4]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h1234};
    vecs[5]  = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 16'h1234};
    vecs[6]  = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h1234};
    vecs[7]  = '{1'b1, 8'h9A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 16'h1234};
    vecs[8]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h9ABC};
    vecs[9]  = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h9ABC};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h9ABC};
    vecs[11] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h9ABC};
    vecs[12] = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h1234};

    for (int n = 0; n < 13; n++) begin
      applyStimulus(vecs[n].iv, vecs[n].i, vecs[n].flush, vecs[n].consume);
      #1;
      checkOutput($sformatf("v%0d IReady", n), 32'(busA.IReady),
                  32'(DB ? vecs[n].rdyD : vecs[n].rdyS));
      stepEdge();
      checkA($sformatf("v%0d", n), vecs[n].irv, vecs[n].bc, vecs[n].ir);
    end

`ifdef IFR_DOUBLE_BUFFER_EN
    // Held 0x1234: next beat fills behind it, the completing beat waits for Consume.
    applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
    #1;
    checkOutput("db 56 IReady", 32'(busA.IReady), 32'd1);
    stepEdge();
    checkA("db 56", 1'b1, 2'd1, 16'h1234);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
    #1;
    checkOutput("db 78 stall IReady", 32'(busA.IReady), 32'd0);
    stepEdge();
    checkA("db 78 stall", 1'b1, 2'd1, 16'h1234);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    #1;
    checkOutput("db 78 consume IReady", 32'(busA.IReady), 32'd1);
    stepEdge();
    checkA("db back-to-back", 1'b1, 2'd0, 16'h5678);
`else
    // Held 0x1234 with a waiting beat: no fill until Consume.
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("stall%0d IReady", n), 32'(busA.IReady), 32'd0);
      stepEdge();
      checkA($sformatf("stall%0d", n), 1'b1, 2'd0, 16'h1234);
    end
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
    #1;
    checkOutput("consume 11 IReady", 32'(busA.IReady), 32'd1);
    stepEdge();
    checkA("consume 11", 1'b0, 2'd1, 16'h1234);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    stepEdge();
    checkA("after 11 22", 1'b1, 2'd0, 16'h1122);
`endif

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    stepEdge();
    checkOutput("release IRValid", 32'(busA.IRValid), 32'd0);

    busB.IValid = 1'b1;
    busB.I      = 8'hAB;
    stepEdge();
    checkOutput("B AB ByteCount", 32'(busB.ByteCount), 32'd1);
    busB.I = 8'hCD;
    stepEdge();
    busB.IValid = 1'b0;
    checkOutput("B IRValid", 32'(busB.IRValid), 32'd1);
    checkOutput("B IROut", 32'(busB.IROut), 32'h0000CDAB);

    beatC(8'h01, 1'b0, 2'd1, 1'b0);
    beatC(8'h02, 1'b0, 2'd2, 1'b0);
    beatC(8'h03, 1'b1, 2'd0, 1'b0);
    busC.Flush = 1'b0;
    beatC(8'h04, 1'b0, 2'd1, 1'b0);
    beatC(8'h05, 1'b0, 2'd2, 1'b0);
    beatC(8'h06, 1'b0, 2'd3, 1'b0);
    beatC(8'h07, 1'b0, 2'd0, 1'b1);
    busC.IValid = 1'b0;
    checkOutput("C IROut", busC.IROut, 32'h04050607);

    // Reset in the middle of an assembly wipes everything, including the old held word.
    applyStimulus(1'b1, 8'h9F, 1'b0, 1'b0);
    stepEdge();
    checkOutput("pre-reset ByteCount", 32'(busA.ByteCount), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b1;
    stepEdge();
    Reset = 1'b0;
    stepEdge();
    checkA("mid reset", 1'b0, 2'd0, 16'h0000);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
